day_11_down_counter_with_load: RTL

//  Loadable down-counter/timer, companion to the loadable up-counter: counts a loaded

---
 rtl/day_11_down_counter_with_load.sv | 97 +++++++++
 1 files changed

// File: rtl/day_11_down_counter_with_load.sv
// Loadable down-counter / interval timer.
// Counts a loaded value down to zero and pulses tc_o for one cycle on the
// terminal event. It has start/pause control and optional auto-reload.
// A RUN state always holds a non-zero count, so the count never wraps below zero.
module day_11_down_counter_with_load #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             pause_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             tc_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    // Next-state logic. Load overrides everything, and the FSM decides the rest.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_val_i;
            reload_d = load_val_i;
            state_d  = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A zero count has nothing to time, so start is ignored.
                    if (start_i && count_q != '0) state_d = S_RUN;
                end
                S_RUN: begin
                    // start_i is ignored here. Pause just freezes the count.
                    if (!pause_i && count_q != '0) begin
                        if (count_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = S_DONE;
                            end
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (start_i && reload_q != '0) begin
                        count_d = reload_q;
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count_o = count_q;
    assign busy_o  = (state_q == S_RUN);
    assign tc_o    = tc_q;
    assign done_o  = (state_q == S_DONE) && (AUTO_RELOAD == 1'b0);

endmodule
